mem_data_arbiter: RTL

Shares the single data RAM port between the pipeline MEM stage and the program/data loader. It arbitrates round-robin between the two requesters and splits 64-bit stores into two 32-bit RAM write beats, because the RAM writes at most 4 bytes per cycle. It returns read data and a per-requester acknowledge, and stalls the pipeline while the pipeline's access is pending. It sits between the MEM stage / loader and the data RAM.

---
 rtl/mem_data_arbiter_pkg.sv | 15 +
 rtl/mem_data_arbiter_rr_arbiter2.sv | 19 +
 rtl/mem_data_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_data_arbiter_pkg.sv
// mem_data_arbiter_pkg: shared encodings for the data-port arbiter
package mem_data_arbiter_pkg;
  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  localparam logic OWN_P = 1'b0;
  localparam logic OWN_L = 1'b1;
  typedef enum logic {S_IDLE, S_BEAT2} state_t;
  function automatic logic [1:0] eff_size(input logic [1:0] s, input int xlen);
    return (xlen == XLEN_32B && s == SIZE_D) ? SIZE_W : s;
  endfunction
endpackage

// File: rtl/mem_data_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, index 0 wins the first tie
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  // grant the lone requester, or on a tie the one that did not win last
  always_comb begin
    gnt[0] = en & req[0] & (~req[1] | last);
    gnt[1] = en & req[1] & (~req[0] | ~last);
  end
  // remember the most recent winner
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares the data RAM port between MEM stage and loader
module mem_data_arbiter
  import mem_data_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_64B,
  localparam int W = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic         i_p_req,
  input  logic         i_p_we,
  input  logic [W-1:0] i_p_addr,
  input  logic [W-1:0] i_p_wdata,
  input  logic [1:0]   i_p_size,
  output logic         o_p_ack,
  output logic         o_p_stall,
  output logic [W-1:0] o_p_rdata,
  input  logic         i_l_req,
  input  logic         i_l_we,
  input  logic [W-1:0] i_l_addr,
  input  logic [W-1:0] i_l_wdata,
  input  logic [1:0]   i_l_size,
  output logic         o_l_ack,
  output logic [W-1:0] o_l_rdata,
  output logic         o_ram_write,
  output logic [W-1:0] o_ram_addr,
  output logic [W-1:0] o_ram_data,
  output logic         o_ram_store_byte,
  output logic         o_ram_store_half,
  input  logic [W-1:0] i_ram_data
);
  state_t state, state_nx;
  logic owner, owner_nx, arb_en, beat2, sel, req_s, we_s, dbl, ack;
  logic [1:0] gnt, sz;
  logic [W-1:0] ad, wd;
  assign arb_en = i_clk_en & ~i_rst & (state == S_IDLE);
  rr_arbiter2 u_arb (
    .clk(i_clk),
    .rst(i_rst),
    .en(arb_en),
    .req({i_l_req, i_p_req}),
    .gnt(gnt)
  );
  // select the active requester, drive the RAM beat and compute next state
  always_comb begin
    beat2 = (state == S_BEAT2) & ~i_rst;
    sel = beat2 ? owner : gnt[1];
    req_s = sel ? i_l_req : i_p_req;
    we_s = sel ? i_l_we : i_p_we;
    sz = eff_size(sel ? i_l_size : i_p_size, XLEN);
    ad = sel ? i_l_addr : i_p_addr;
    wd = sel ? i_l_wdata : i_p_wdata;
    dbl = we_s & (sz == SIZE_D);
    state_nx = state;
    owner_nx = owner;
    ack = 1'b0;
    o_ram_write = 1'b0;
    o_ram_addr = ad;
    o_ram_data = wd;
    o_ram_store_byte = 1'b0;
    o_ram_store_half = 1'b0;
    if (beat2 & i_clk_en) begin
      state_nx = S_IDLE;
      o_ram_write = req_s;
      ack = req_s;
      o_ram_addr = ad + W'(4);
      o_ram_data = wd >> 32;
    end else if (|gnt) begin
      o_ram_write = we_s;
      ack = ~dbl;
      o_ram_store_byte = we_s & (sz == SIZE_B);
      o_ram_store_half = we_s & (sz == SIZE_H);
      if (dbl) begin
        state_nx = S_BEAT2;
        owner_nx = sel;
        o_ram_data = wd & W'(32'hFFFF_FFFF);
      end
    end
    o_p_ack = ack & ~sel;
    o_l_ack = ack & sel;
    o_p_stall = i_p_req & ~o_p_ack;
    o_p_rdata = i_rst ? '0 : i_ram_data;
    o_l_rdata = i_rst ? '0 : i_ram_data;
  end
  // state and owner advance only on enabled cycles
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_IDLE;
      owner <= OWN_P;
    end else if (i_clk_en) begin
      state <= state_nx;
      owner <= owner_nx;
    end
endmodule
